// File: rtl/md_countdown_ctrl_if.sv
// Control/status bundle for md_countdown_ctrl.
// master: the side that drives start/hold/abort/load_val and observes status.
// slave: the countdown controller itself.
interface md_countdown_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic             hold;
  logic             abort;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;
  logic             busy;
  logic             done;
  logic [3:0]       reloads;

  modport master (
    output start, hold, abort, load_val,
    input  count, state, busy, done, reloads
  );

  modport slave (
    input  start, hold, abort, load_val,
    output count, state, busy, done, reloads
  );
endinterface

// File: rtl/md_countdown_ctrl.sv
// Programmable countdown controller: loads a start value, decrements it once every
// TICK_DIV clocks, supports hold/resume and abort, and pulses done on terminal count.
// Optional feature macro: MD_CDC_AUTO_RELOAD_EN (auto-reload from load_val on terminal
// count, with a saturating reload counter). Undefined: one-shot, reloads stays 0.
module md_countdown_ctrl #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  md_countdown_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

  // Prescaler compares against the last phase of the tick period.
  localparam logic [7:0] TickMax = 8'(TICK_DIV - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_presc;
  logic             r_busy;
  logic             r_done;
  logic [3:0]       r_reloads;

  state_e           w_state_d;
  logic [CNT_W-1:0] w_count_d;
  logic [7:0]       w_presc_d;
  logic             w_done_d;
  logic [3:0]       w_reloads_d;
  logic             w_tick;

  assign w_tick = (r_presc == TickMax);

  // Next-state logic; priority is abort > start (idle only) > hold > tick.
  always_comb begin
    w_state_d   = r_state;
    w_count_d   = r_count;
    w_presc_d   = r_presc;
    w_done_d    = 1'b0;
    w_reloads_d = r_reloads;

    if (bus.abort) begin
      w_state_d = StIdle;
      w_count_d = '0;
      w_presc_d = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            if (bus.load_val != '0) begin
              w_count_d = bus.load_val;
              w_presc_d = '0;
              w_state_d = StRun;
            end else begin
              // Zero-length run: report completion without ever going busy.
              w_done_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (bus.hold) begin
            w_state_d = StPause;
          end else if (w_tick) begin
            w_presc_d = '0;
            if (r_count == CNT_W'(1)) begin
              w_done_d = 1'b1;
`ifdef MD_CDC_AUTO_RELOAD_EN
              w_count_d   = bus.load_val;
              w_reloads_d = (r_reloads == 4'd15) ? r_reloads : r_reloads + 4'd1;
              if (bus.load_val == '0) begin
                w_state_d = StIdle;
              end
`else
              w_count_d = '0;
              w_state_d = StIdle;
`endif
            end else begin
              w_count_d = r_count - CNT_W'(1);
            end
          end else begin
            w_presc_d = r_presc + 8'd1;
          end
        end
        StPause: begin
          // Resume edge does not advance the prescaler.
          if (!bus.hold) begin
            w_state_d = StRun;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_presc   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_reloads <= '0;
    end else begin
      r_state   <= w_state_d;
      r_count   <= w_count_d;
      r_presc   <= w_presc_d;
      r_busy    <= (w_state_d != StIdle);
      r_done    <= w_done_d;
      r_reloads <= w_reloads_d;
    end
  end

  assign bus.count   = r_count;
  assign bus.state   = r_state;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.reloads = r_reloads;

endmodule

// File: tb/tb_md_countdown_ctrl.sv
// Directed self-checking bench for md_countdown_ctrl. Uses one DUT with TICK_DIV=4
// and one with TICK_DIV=1; auto-reload expectations follow MD_CDC_AUTO_RELOAD_EN.
module tb_md_countdown_ctrl;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  md_countdown_ctrl_if #(.CNT_W(4)) u_if ();
  md_countdown_ctrl_if #(.CNT_W(4)) u_if1 ();

  md_countdown_ctrl #(.CNT_W(4), .TICK_DIV(4)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if)
  );

  md_countdown_ctrl #(.CNT_W(4), .TICK_DIV(1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if1)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    #3;
    obs = {u_if.count, u_if.state, u_if.busy, u_if.done, u_if.reloads};
    if (obs !== 12'h000) $display("FAIL reset_initial got=%h exp=%h", obs, 12'h000);
    else n_pass++;
    n_total++;
    rst_n = 1'b1;
    step();
    // Mid-run asynchronous reset with count=9.
    u_if.load_val = 4'd9;
    u_if.start    = 1'b1;
    step();
    u_if.start = 1'b0;
    step();
    obs = {u_if.count, u_if.state, u_if.busy, u_if.done, 4'h0};
    if (obs !== {4'd9, 2'b01, 1'b1, 1'b0, 4'h0})
      $display("FAIL reset_prerun got=%h exp=%h", obs, {4'd9, 2'b01, 1'b1, 1'b0, 4'h0});
    else n_pass++;
    n_total++;
    rst_n = 1'b0;
    #1;
    obs = {u_if.count, u_if.state, u_if.busy, u_if.done, u_if.reloads};
    if (obs !== 12'h000) $display("FAIL reset_async got=%h exp=%h", obs, 12'h000);
    else n_pass++;
    n_total++;
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] obs;
    logic [7:0] exp;
    logic [3:0] ec;
    u_if.load_val = 4'd5;
    u_if.start    = 1'b1;
    step();
    u_if.start = 1'b0;
    obs = {u_if.count, u_if.state, u_if.busy, u_if.done};
    exp = {4'd5, 2'b01, 1'b1, 1'b0};
    if (obs !== exp) $display("FAIL basic_load got=%h exp=%h", obs, exp);
    else n_pass++;
    n_total++;
    for (int k = 1; k <= 20; k++) begin
      step();
      ec  = (k == 20) ? 4'd0 : 4'(5 - k / 4);
      exp = (k == 20) ? {ec, 2'b00, 1'b0, 1'b1} : {ec, 2'b01, 1'b1, 1'b0};
      obs = {u_if.count, u_if.state, u_if.busy, u_if.done};
      if (obs !== exp) $display("FAIL basic_k%0d got=%h exp=%h", k, obs, exp);
      else n_pass++;
      n_total++;
    end
    step();
    if (u_if.done !== 1'b0) $display("FAIL basic_done_once got=%b exp=0", u_if.done);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_hold();
    logic [7:0] obs;
    logic [7:0] exp;
    logic [3:0] ec;
    u_if.load_val = 4'd6;
    u_if.start    = 1'b1;
    step();
    u_if.start = 1'b0;
    // Edges E0+1..E0+10: count 4 from E0+8, prescaler at 2 after E0+10.
    for (int e = 1; e <= 10; e++) step();
    u_if.hold = 1'b1;
    for (int e = 11; e <= 17; e++) begin
      step();
      obs = {u_if.count, u_if.state, u_if.busy, u_if.done};
      exp = {4'd4, 2'b10, 1'b1, 1'b0};
      if (obs !== exp) $display("FAIL hold_e%0d got=%h exp=%h", e, obs, exp);
      else n_pass++;
      n_total++;
    end
    u_if.hold = 1'b0;
    for (int e = 18; e <= 32; e++) begin
      step();
      ec  = (e < 20) ? 4'd4 : (e < 24) ? 4'd3 : (e < 28) ? 4'd2 : (e < 32) ? 4'd1 : 4'd0;
      exp = (e == 32) ? {ec, 2'b00, 1'b0, 1'b1} : {ec, 2'b01, 1'b1, 1'b0};
      obs = {u_if.count, u_if.state, u_if.busy, u_if.done};
      if (obs !== exp) $display("FAIL resume_e%0d got=%h exp=%h", e, obs, exp);
      else n_pass++;
      n_total++;
    end
    step();
  endtask

  task automatic test_abort();
    logic [7:0] obs;
    logic [7:0] exp;
    u_if.load_val = 4'd5;
    u_if.start    = 1'b1;
    step();
    u_if.start = 1'b0;
    for (int e = 1; e <= 8; e++) step();
    u_if.hold = 1'b1;
    step();
    // start while busy must not reload.
    u_if.load_val = 4'd9;
    u_if.start    = 1'b1;
    step();
    obs = {u_if.count, u_if.state, u_if.busy, u_if.done};
    exp = {4'd3, 2'b10, 1'b1, 1'b0};
    if (obs !== exp) $display("FAIL abort_pause_start got=%h exp=%h", obs, exp);
    else n_pass++;
    n_total++;
    u_if.start = 1'b0;
    u_if.abort = 1'b1;
    step();
    u_if.abort = 1'b0;
    u_if.hold  = 1'b0;
    obs = {u_if.count, u_if.state, u_if.busy, u_if.done};
    exp = 8'h00;
    if (obs !== exp) $display("FAIL abort_idle got=%h exp=%h", obs, exp);
    else n_pass++;
    n_total++;
    for (int e = 0; e < 6; e++) begin
      step();
      if (u_if.done !== 1'b0 || u_if.busy !== 1'b0)
        $display("FAIL abort_after_e%0d got=%b%b exp=00", e, u_if.done, u_if.busy);
      else n_pass++;
      n_total++;
    end
  endtask

  task automatic test_zero_load();
    logic [7:0] obs;
    logic [7:0] exp;
    u_if.load_val = 4'd0;
    u_if.start    = 1'b1;
    step();
    u_if.start = 1'b0;
    obs = {u_if.count, u_if.state, u_if.busy, u_if.done};
    exp = {4'd0, 2'b00, 1'b0, 1'b1};
    if (obs !== exp) $display("FAIL zero_done got=%h exp=%h", obs, exp);
    else n_pass++;
    n_total++;
    step();
    obs = {u_if.count, u_if.state, u_if.busy, u_if.done};
    exp = 8'h00;
    if (obs !== exp) $display("FAIL zero_after got=%h exp=%h", obs, exp);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] obs;
    logic [7:0] exp;
    u_if.load_val = 4'd1;
    u_if.start    = 1'b1;
    step();
    for (int e = 1; e <= 5; e++) begin
      step();
      exp = (e == 4) ? {4'd0, 2'b00, 1'b0, 1'b1} : {4'd1, 2'b01, 1'b1, 1'b0};
      obs = {u_if.count, u_if.state, u_if.busy, u_if.done};
      if (obs !== exp) $display("FAIL b2b_e%0d got=%h exp=%h", e, obs, exp);
      else n_pass++;
      n_total++;
    end
    u_if.start = 1'b0;
    u_if.abort = 1'b1;
    step();
    u_if.abort = 1'b0;
    obs = {u_if.count, u_if.state, u_if.busy, u_if.done};
    if (obs !== 8'h00) $display("FAIL b2b_abort got=%h exp=%h", obs, 8'h00);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_reload();
    logic [11:0] obs;
    logic [11:0] exp;
    logic [3:0]  er;
    u_if1.load_val = 4'd2;
    u_if1.start    = 1'b1;
    step();
    u_if1.start = 1'b0;
`ifdef MD_CDC_AUTO_RELOAD_EN
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) step();
      er  = (k / 2 > 15) ? 4'd15 : 4'(k / 2);
      exp = {(k % 2 == 0) ? 4'd2 : 4'd1, 2'b01, 1'b1, (k > 0 && k % 2 == 0), er};
      obs = {u_if1.count, u_if1.state, u_if1.busy, u_if1.done, u_if1.reloads};
      if (obs !== exp) $display("FAIL reload_k%0d got=%h exp=%h", k, obs, exp);
      else n_pass++;
      n_total++;
    end
    u_if1.abort = 1'b1;
    step();
    u_if1.abort = 1'b0;
    exp = {4'd0, 2'b00, 1'b0, 1'b0, 4'd15};
`else
    for (int k = 0; k <= 2; k++) begin
      if (k > 0) step();
      er  = 4'd0;
      exp = (k == 2) ? {4'd0, 2'b00, 1'b0, 1'b1, er} : {4'(2 - k), 2'b01, 1'b1, 1'b0, er};
      obs = {u_if1.count, u_if1.state, u_if1.busy, u_if1.done, u_if1.reloads};
      if (obs !== exp) $display("FAIL oneshot_k%0d got=%h exp=%h", k, obs, exp);
      else n_pass++;
      n_total++;
    end
    step();
    exp = 12'h000;
`endif
    obs = {u_if1.count, u_if1.state, u_if1.busy, u_if1.done, u_if1.reloads};
    if (obs !== exp) $display("FAIL reload_end got=%h exp=%h", obs, exp);
    else n_pass++;
    n_total++;
  endtask

  initial begin
    clk            = 1'b0;
    rst_n          = 1'b0;
    n_pass         = 0;
    n_total        = 0;
    u_if.start     = 1'b0;
    u_if.hold      = 1'b0;
    u_if.abort     = 1'b0;
    u_if.load_val  = 4'd0;
    u_if1.start    = 1'b0;
    u_if1.hold     = 1'b0;
    u_if1.abort    = 1'b0;
    u_if1.load_val = 4'd0;
    test_reset();
    test_basic();
    test_hold();
    test_abort();
    test_zero_load();
    test_back_to_back();
    test_reload();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
